// File: rtl/axi_beat_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_beat_addr_gen
//
// Purpose:
//   Takes one AXI-style burst command (id, start address, length, size,
//   burst type) and expands it into a stream of per-beat addresses. It
//   supports FIXED, INCR and WRAP bursts. The reserved burst encoding 2'b11
//   is handled as INCR. A WRAP command whose length is not 2, 4, 8 or 16
//   beats is also handled as INCR. A beat size larger than the data bus is
//   clamped to the bus width when the command is latched.
//
//   Only one command is in flight at a time. A new command is accepted only
//   after the last beat of the previous burst has been consumed.
//
// Handshakes:
//   Both interfaces use valid/ready. A transfer happens on a rising clock
//   edge where valid and ready are both high. Once valid is asserted, it and
//   the payload stay stable until the transfer completes. Ready may change
//   freely.
//
// Configuration:
//   AXI_4K_CHECK_EN - when defined, adds output cmd_err. It pulses for one
//                     cycle after an INCR command is accepted whose last
//                     beat lies in a different 4 KB page than the start
//                     address. The burst is still issued unchanged. When the
//                     macro is undefined, the port and its logic do not
//                     exist.
//
// Ports:
//   clk         in   clock; all logic on the rising edge
//   reset       in   synchronous active-high reset
//   cmd_valid   in   burst command valid
//   cmd_ready   out  high only in IDLE and never while reset is high
//   cmd_id      in   burst ID
//   cmd_addr    in   start address
//   cmd_len     in   number of beats minus one
//   cmd_size    in   log2 of bytes per beat
//   cmd_burst   in   00 FIXED, 01 INCR, 10 WRAP, 11 reserved (as INCR)
//   beat_valid  out  beat address valid, high only in BURST
//   beat_ready  in   beat consumed when beat_valid && beat_ready
//   beat_id     out  latched command ID
//   beat_addr   out  address of the current beat
//   beat_idx    out  current beat number, 0..len
//   beat_last   out  high on the final beat of the burst
//   cmd_err     out  (AXI_4K_CHECK_EN only) 4 KB crossing pulse
// ---------------------------------------------------------------------------
module axi_beat_addr_gen #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [AXI_ID_WIDTH-1:0]   beat_id,
    output logic [AXI_ADDR_WIDTH-1:0] beat_addr,
    output logic [AXI_LEN_WIDTH-1:0]  beat_idx,
    output logic                      beat_last
`ifdef AXI_4K_CHECK_EN
    ,
    output logic                      cmd_err
`endif
);

    localparam int AW           = AXI_ADDR_WIDTH;
    localparam int LW           = AXI_LEN_WIDTH;
    localparam int MAX_SIZE_INT = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [2:0] MAX_SIZE = 3'(MAX_SIZE_INT);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Effective addressing mode, resolved once when the command is latched.
    // Reserved bursts and WRAP bursts with an illegal length both become INCR.
    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_WRAP  = 2'd2
    } mode_t;

    state_t          state;
    state_t          state_nxt;

    // Burst context latched at command acceptance.
    mode_t           mode_q;
    logic [LW-1:0]   len_q;
    logic [AW-1:0]   inc_q;        // bytes per beat after clamping
    logic [AW-1:0]   wrap_base_q;  // lowest address of the wrap window
    logic [AW-1:0]   wrap_end_q;   // first address past the wrap window

    // Command decode.
    logic [2:0]      cmd_size_eff;
    logic [AW-1:0]   cmd_inc;
    logic [AW-1:0]   cmd_span;
    logic [AW-1:0]   cmd_base;
    logic            cmd_len_wrappable;
    mode_t           cmd_mode;

    // Next-beat address candidates.
    logic [AW-1:0]   incr_addr;
    logic [AW-1:0]   wrap_addr;
    logic [AW-1:0]   addr_nxt;

    logic            last_hit;
    logic            cmd_fire;
    logic            beat_fire;

    // -----------------------------------------------------------------------
    // Command decode: clamp the size and build the wrap window.
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_size_eff      = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
        cmd_inc           = AW'(1) << cmd_size_eff;
        cmd_span          = (AW'(cmd_len) + AW'(1)) << cmd_size_eff;
        cmd_base          = cmd_addr & ~(cmd_span - AW'(1));
        cmd_len_wrappable = (cmd_len == LW'(1)) || (cmd_len == LW'(3)) ||
                            (cmd_len == LW'(7)) || (cmd_len == LW'(15));
        case (cmd_burst)
            2'b00:   cmd_mode = MODE_FIXED;
            2'b10:   cmd_mode = cmd_len_wrappable ? MODE_WRAP : MODE_INCR;
            default: cmd_mode = MODE_INCR;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next beat address.
    // INCR aligns the current address down before stepping. Only the first
    // beat can be unaligned, so this gives aligned_start + n*inc for n > 0.
    // WRAP steps and folds back to the base when it reaches the window end.
    // If the window sits at the top of the address space, both sides of the
    // compare overflow to the same value, so the fold still happens.
    // -----------------------------------------------------------------------
    always_comb begin
        incr_addr = (beat_addr & ~(inc_q - AW'(1))) + inc_q;
        wrap_addr = beat_addr + inc_q;
        if (wrap_addr == wrap_end_q) begin
            wrap_addr = wrap_base_q;
        end
        case (mode_q)
            MODE_FIXED: addr_nxt = beat_addr;
            MODE_WRAP:  addr_nxt = wrap_addr;
            default:    addr_nxt = incr_addr;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and handshake outputs.
    // cmd_ready is gated by reset so that no command can be accepted
    // while reset is high.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        last_hit   = (beat_idx == len_q);
        case (state)
            IDLE: begin
                cmd_ready = ~reset;
                if (cmd_valid) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                beat_valid = 1'b1;
                beat_last  = last_hit;
                if (beat_ready && last_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat_fire = beat_valid & beat_ready;

    // -----------------------------------------------------------------------
    // Beat datapath and latched burst context.
    // The registers stop changing on the last beat. They keep their final
    // values in IDLE until the next command reloads them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_id     <= '0;
            beat_addr   <= '0;
            beat_idx    <= '0;
            len_q       <= '0;
            inc_q       <= '0;
            mode_q      <= MODE_FIXED;
            wrap_base_q <= '0;
            wrap_end_q  <= '0;
        end else if (cmd_fire) begin
            beat_id     <= cmd_id;
            beat_addr   <= cmd_addr;
            beat_idx    <= '0;
            len_q       <= cmd_len;
            inc_q       <= cmd_inc;
            mode_q      <= cmd_mode;
            wrap_base_q <= cmd_base;
            wrap_end_q  <= cmd_base + cmd_span;
        end else if (beat_fire && !last_hit) begin
            beat_idx    <= beat_idx + LW'(1);
            beat_addr   <= addr_nxt;
        end
    end

`ifdef AXI_4K_CHECK_EN
    // -----------------------------------------------------------------------
    // 4 KB page crossing check for INCR commands, evaluated at acceptance.
    // The last beat address uses the same formula as the beat generator:
    // aligned_start + len*inc. Wrap-around of the address space counts as
    // a page change.
    // -----------------------------------------------------------------------
    logic [AW-1:0] cmd_last_addr;
    logic          cmd_crosses_4k;

    always_comb begin
        cmd_last_addr  = (cmd_addr & ~(cmd_inc - AW'(1))) +
                         (AW'(cmd_len) << cmd_size_eff);
        cmd_crosses_4k = (cmd_burst == 2'b01) &&
                         (cmd_addr[AW-1:12] != cmd_last_addr[AW-1:12]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_fire & cmd_crosses_4k;
        end
    end
`endif

endmodule

// File: tb/tb_axi_beat_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_axi_beat_addr_gen
//
// Bench for axi_beat_addr_gen.
// - A table of command vectors is applied in a loop. Each command pushes its
//   predicted beats (id, addr, idx, last) into exp_q as it is driven.
// - A negedge monitor compares every visible beat against the head of exp_q
//   and pops the head on each beat handshake.
// - Directed sequences cover beat timing and reset in the middle of a burst.
// - A short random run follows.
// ---------------------------------------------------------------------------
module tb_axi_beat_addr_gen;

  localparam int IDW = 6;
  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int EW  = IDW + AW + LW + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_id;
  logic [AW-1:0]  cmd_addr;
  logic [LW-1:0]  cmd_len;
  logic [2:0]     cmd_size;
  logic [1:0]     cmd_burst;
  logic           beat_valid;
  logic           beat_ready;
  logic [IDW-1:0] beat_id;
  logic [AW-1:0]  beat_addr;
  logic [LW-1:0]  beat_idx;
  logic           beat_last;
`ifdef AXI_4K_CHECK_EN
  logic           cmd_err;
`endif

  axi_beat_addr_gen #(
    .AXI_ID_WIDTH  (IDW),
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .AXI_LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_id   (beat_id),
    .beat_addr (beat_addr),
    .beat_idx  (beat_idx),
    .beat_last (beat_last)
`ifdef AXI_4K_CHECK_EN
    ,
    .cmd_err   (cmd_err)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;
  int last_pop_cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: toggle
  bit mon_en = 1'b0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
    logic [2:0]     size;
    logic [1:0]     burst;
    int             rmode;
    bit             exp_err;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event missing within bound, expected it to occur", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] start, input logic [LW-1:0] len,
                                               input logic [2:0] size, input logic [1:0] burst, input int n);
    logic [2:0]    sz;
    logic [AW-1:0] inc, span, base;
    bit            wrap_ok;
    sz = (size > 3'd2) ? 3'd2 : size;
    inc = 64'd1 << sz;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && wrap_ok) begin
      span = (64'(len) + 64'd1) << sz;
      base = start & ~(span - 64'd1);
      return base + ((start - base + 64'(n) * inc) & (span - 64'd1));
    end
    if (n == 0) return start;
    return (start & ~(inc - 64'd1)) + 64'(n) * inc;
  endfunction

  function automatic bit model_err(input logic [AW-1:0] start, input logic [LW-1:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] last;
    last = model_addr(start, len, size, burst, int'(len));
    return (burst == 2'b01) && (start[AW-1:12] != last[AW-1:12]);
  endfunction

  // ---------------- beat_ready driver ----------------
  initial begin
    beat_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       beat_ready = 1'b1;
        1:       beat_ready = 1'($urandom_range(0, 1));
        default: beat_ready = ~beat_ready;
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("ready_vs_valid", cmd_ready, !beat_valid);
      if (beat_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          chk("beat", {beat_id, beat_addr, beat_idx, beat_last}, exp_q[0]);
          if (beat_ready) begin
            void'(exp_q.pop_front());
            pops <= pops + 1;
            last_pop_cyc <= cyc;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit exp_err,
                          output int accept_cyc);
    int t = 0;
    accept_cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      fail("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    for (int n = 0; n <= int'(len); n++)
      exp_q.push_back({id, model_addr(addr, len, size, burst, n), LW'(n), (n == int'(len))});
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
`ifdef AXI_4K_CHECK_EN
    @(negedge clk);
    chk("cmd_err_pulse", cmd_err, exp_err);
    @(negedge clk);
    chk("cmd_err_single", cmd_err, 1'b0);
`endif
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      fail("drain_timeout");
      exp_q.delete();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
    end else begin
      @(negedge clk);
      #1;
      chk("idle_after_last", {cmd_ready, beat_valid}, 2'b10);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int t;
    int p0;
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    logic [2:0]    rs;
    logic [1:0]    rb;

    reset = 1'b1; cmd_valid = 1'b0;
    cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;

    tbl[0]  = '{6'd1,  64'h1000,               8'd3,   3'd2, 2'b01, 0, 1'b0};
    tbl[1]  = '{6'd2,  64'h100C,               8'd3,   3'd2, 2'b10, 0, 1'b0};
    tbl[2]  = '{6'd3,  64'h1003,               8'd1,   3'd2, 2'b01, 2, 1'b0};
    tbl[3]  = '{6'd4,  64'h20,                 8'd2,   3'd2, 2'b00, 1, 1'b0};
    tbl[4]  = '{6'd5,  64'h2344,               8'd0,   3'd2, 2'b01, 0, 1'b0};
    tbl[5]  = '{6'd6,  64'h3000,               8'd3,   3'd5, 2'b01, 1, 1'b0};
    tbl[6]  = '{6'd7,  64'h4008,               8'd2,   3'd2, 2'b10, 0, 1'b0};
    tbl[7]  = '{6'd8,  64'h5006,               8'd3,   3'd1, 2'b11, 1, 1'b0};
    tbl[8]  = '{6'd9,  64'hFFFF_FFFF_FFFF_FFF8, 8'd3,  3'd2, 2'b01, 0, 1'b1};
    tbl[9]  = '{6'd10, 64'h601A,               8'd7,   3'd1, 2'b10, 1, 1'b0};
    tbl[10] = '{6'd11, 64'hFF8,                8'd3,   3'd2, 2'b01, 0, 1'b1};
    tbl[11] = '{6'd12, 64'hFF0,                8'd3,   3'd2, 2'b01, 0, 1'b0};
    tbl[12] = '{6'd13, 64'h7020,               8'd15,  3'd2, 2'b10, 1, 1'b0};
    tbl[13] = '{6'd14, 64'h8000,               8'd255, 3'd0, 2'b01, 0, 1'b0};

    // Reset behaviour.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", cmd_ready, 1'b0);
    chk("valid_in_reset", beat_valid, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_beat_valid", beat_valid, 1'b0);
    chk("rst_beat_last", beat_last, 1'b0);
    chk("rst_beat_idx", beat_idx, 0);
    chk("rst_beat_addr", beat_addr, 0);
    chk("rst_beat_id", beat_id, 0);
    mon_en = 1'b1;

    // Table vectors.
    for (int i = 0; i < 14; i++) begin
      ready_mode = tbl[i].rmode;
      send_cmd(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].exp_err, acc);
      wait_idle();
    end

    // Four INCR beats on four consecutive cycles with ready held high.
    ready_mode = 0;
    send_cmd(6'd20, 64'h1000, 8'd3, 3'd2, 2'b01, 1'b0, acc);
    wait_idle();
    chk("incr_back_to_back", last_pop_cyc - acc, 3);

    // Reset after the second beat of a len=7 INCR burst.
    ready_mode = 0;
    p0 = pops;
    send_cmd(6'd21, 64'h9000, 8'd7, 3'd2, 2'b01, 1'b0, acc);
    t = 0;
    while (pops < p0 + 2 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (pops < p0 + 2) fail("mid_burst_beats");
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("abandon_valid", beat_valid, 1'b0);
    chk("abandon_ready_in_reset", cmd_ready, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_idx", beat_idx, 0);
    chk("post_rst_valid", beat_valid, 1'b0);
    send_cmd(6'd22, 64'hA004, 8'd2, 3'd2, 2'b01, 1'b0, acc);
    wait_idle();

    // Random commands.
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rl = LW'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      rb = 2'($urandom_range(0, 3));
      if (rb == 2'b10) ra = ra & ~((64'd1 << ((rs > 3'd2) ? 3'd2 : rs)) - 64'd1);
      ready_mode = $urandom_range(0, 2);
      send_cmd(IDW'($urandom), ra, rl, rs, rb, model_err(ra, rl, rs, rb), acc);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_beat_addr_gen.md
AXI_BEAT_ADDR_GEN -- requirements
Module: axi_beat_addr_gen

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 6, width of ID fields.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64, width of address fields.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 32, data bus width in bits; max beat size = $clog2(AXI_DATA_WIDTH/8).
REQ-004 SHALL have parameter AXI_LEN_WIDTH, default 8, width of burst length fields.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 cmd_valid  input  1  burst command valid.
REQ-009 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-010 cmd_id  input  AXI_ID_WIDTH  burst ID.
REQ-011 cmd_addr  input  AXI_ADDR_WIDTH  start address.
REQ-012 cmd_len  input  AXI_LEN_WIDTH  beats minus one.
REQ-013 cmd_size  input  3  log2 bytes per beat.
REQ-014 cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-015 beat_valid  output  1  beat address valid.
REQ-016 beat_ready  input  1  beat consumed when beat_valid && beat_ready.
REQ-017 beat_id  output  AXI_ID_WIDTH  latched cmd_id.
REQ-018 beat_addr  output  AXI_ADDR_WIDTH  address of current beat.
REQ-019 beat_idx  output  AXI_LEN_WIDTH  beat number, 0..len.
REQ-020 beat_last  output  1  high when beat_idx == latched len.

Function
REQ-021 SHALL implement states IDLE and BURST; cmd_ready = 1 only in IDLE, beat_valid = 1 only in BURST.
REQ-022 Command handshake in IDLE SHALL latch id/addr/len/size/burst and enter BURST next cycle with beat_idx=0, beat_addr=cmd_addr.
REQ-023 Beat handshake SHALL advance beat_idx by 1 and beat_addr per REQ-025..027 in the next cycle; beat_valid and outputs SHALL hold stable while beat_ready is low.
REQ-024 Beat handshake with beat_last=1 SHALL return to IDLE; cmd_ready asserts the following cycle (no command overlap).
REQ-025 FIXED: every beat_addr = start address.
REQ-026 INCR and reserved 11: beat n>0 address = (start & ~(2^size-1)) + n*2^size, modulo 2^AXI_ADDR_WIDTH (64-bit wrap-around silent).
REQ-027 WRAP: span = (len+1)*2^size, base = start & ~(span-1); next = addr+2^size, replaced by base when it equals base+span.
REQ-028 WRAP with len not in {1,3,7,15} SHALL be treated as INCR.
REQ-029 cmd_size above $clog2(AXI_DATA_WIDTH/8) SHALL be clamped to that value at latch time.
REQ-030 len=0 SHALL produce exactly one beat with beat_last=1.

Reset
REQ-031 reset SHALL force IDLE, cmd_ready=1 (from the first cycle after reset release), beat_valid=0, beat_last=0, beat_idx=0, beat_addr=0, beat_id=0.
REQ-032 reset mid-burst SHALL abandon the burst; no further beats issued.
REQ-033 cmd_ready SHALL be 0 while reset is high.

Configuration
REQ-034 Macro AXI_4K_CHECK_EN: when defined, output cmd_err (1 bit) pulses one cycle after acceptance of an INCR command whose last beat crosses a 4 KB boundary; burst still issued per REQ-026.
REQ-035 Without AXI_4K_CHECK_EN, cmd_err port and check logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 INCR addr=0x1000, len=3, size=2, beat_ready=1 -> beat_addr 0x1000,0x1004,0x1008,0x100C on 4 consecutive cycles, beat_last on 4th only.
REQ-037 WRAP addr=0x100C, len=3, size=2 -> 0x100C,0x1000,0x1004,0x1008.
REQ-038 INCR unaligned addr=0x1003, len=1, size=2, beat_ready toggling 0/1 -> 0x1003 then 0x1004, each held while beat_ready=0.
REQ-039 FIXED addr=0x20, len=2 -> three beats at 0x20; cmd_ready low until cycle after third handshake.
REQ-040 reset asserted after beat 1 of len=7 INCR -> beat_valid=0 next cycle, cmd_ready=1 after release, new command starts at beat_idx=0.
REQ-041 With AXI_4K_CHECK_EN: INCR addr=0xFF8, len=3, size=2 -> cmd_err pulses once; addr=0xFF0 same len/size -> no pulse.
